// File: rtl/display_scanner.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | display_scanner: multiplexes NUM_DIGITS hex nibbles onto one 7-seg decoder |
// | with frame-aligned word commit. Option: LEADING_ZERO_BLANK_EN.  Rev 1.0    |
// +---------------------------------------------------------------------------+
module display_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    output logic [3:0]              num,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_start
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         idx_next;
    logic [DW-1:0]         shown;
    logic [DW-1:0]         shown_next;
    logic [DW-1:0]         pending;
    logic                  pend_v;
    logic                  tick;
    logic                  boundary;
    logic [NUM_DIGITS-1:0] sel;
    logic [3:0]            nib;
    logic                  blank;

    assign tick     = (presc == PRESC_MAX);
    assign boundary = tick && (idx == IDX_MAX);

    always_comb begin
        idx_next = idx;
        if (tick) begin
            idx_next = (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end
    end

    // A same-cycle load on the boundary bypasses the pending register.
    always_comb begin
        shown_next = shown;
        if (boundary) begin
            if (load) begin
                shown_next = value;
            end else if (pend_v) begin
                shown_next = pending;
            end
        end
    end

    always_comb begin
        sel = '0;
        nib = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_next == IW'(i)) begin
                sel[i] = 1'b1;
                nib    = shown_next[4*i +: 4];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Digit i goes dark when it and every more-significant nibble are zero.
    always_comb begin
        blank = 1'b0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (sel[i] && ((shown_next >> (4*i)) == '0)) begin
                blank = 1'b1;
            end
        end
    end
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            idx   <= idx_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shown   <= '0;
            pending <= '0;
            pend_v  <= 1'b0;
        end else begin
            shown <= shown_next;
            if (load) begin
                pending <= value;
            end
            if (boundary) begin
                pend_v <= 1'b0;
            end else if (load) begin
                pend_v <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num         <= '0;
            an_n        <= '1;
            frame_start <= 1'b0;
        end else begin
            num         <= nib;
            an_n        <= blank ? '1 : ~sel;
            frame_start <= boundary;
        end
    end

endmodule
`default_nettype wire
